// File: rtl/scale_gen_pipe.sv
// scale_gen_pipe
// Multi-lane, two-stage, stallable scale operand generator for the unary
// div/exp/log paths. Stage 1 decodes each lane (leading-one position, sign
// test, exp table lookup); stage 2 applies the per-mode shift/mux and holds
// the result for the downstream multiplier. The exp table is a register
// file shared by all lanes and can be rewritten at any time.

module scale_gen_pipe #(
    parameter int NUM_CH = 4,
    parameter int MUL_BW = 16,
    parameter int FRA_BW = 10,
    parameter int INT_BW = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode_i,
    input  logic [NUM_CH*MUL_BW-1:0] x_i,
    input  logic [NUM_CH*MUL_BW-1:0] y_i,
    input  logic                     lut_we,
    input  logic [INT_BW-1:0]        lut_addr,
    input  logic [MUL_BW-1:0]        lut_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*MUL_BW-1:0] scale_o,
    output logic [NUM_CH-1:0]        dz_o
);

    localparam int LUT_DEPTH = 1 << INT_BW;
    // One extra bit so that p+1 never wraps, whatever MUL_BW is.
    localparam int P_BW = $clog2(MUL_BW) + 1;
    localparam logic [MUL_BW-1:0] LUT_ONE = MUL_BW'(1) << FRA_BW;
    localparam logic [MUL_BW-1:0] MAX_POS = {1'b0, {(MUL_BW-1){1'b1}}};

    typedef enum logic [1:0] {
        MODE_GEMM = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_EXP  = 2'b10,
        MODE_LOG  = 2'b11
    } mode_e;

    // Pipeline control
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv, s1_adv, accept;

    // Stage 1 registers
    mode_e              s1_mode_q, s1_mode_d;
    logic [MUL_BW-1:0]  s1_y_q    [NUM_CH];
    logic [MUL_BW-1:0]  s1_y_d    [NUM_CH];
    logic [P_BW-1:0]    s1_p_q    [NUM_CH];
    logic [P_BW-1:0]    s1_p_d    [NUM_CH];
    logic [NUM_CH-1:0]  s1_npos_q, s1_npos_d;
    logic [MUL_BW-1:0]  s1_lut_q  [NUM_CH];
    logic [MUL_BW-1:0]  s1_lut_d  [NUM_CH];

    // Stage 2 registers
    logic [MUL_BW-1:0]  scale_q   [NUM_CH];
    logic [MUL_BW-1:0]  scale_d   [NUM_CH];
    logic [NUM_CH-1:0]  dz_q, dz_d;

    // Exp table
    logic [MUL_BW-1:0]  lut_q     [LUT_DEPTH];
    logic [MUL_BW-1:0]  lut_d     [LUT_DEPTH];

    // Stage 1 combinational lane decode
    logic [MUL_BW-1:0]  x_lane    [NUM_CH];
    logic [INT_BW-1:0]  idx_lane  [NUM_CH];
    logic [P_BW-1:0]    p_lane    [NUM_CH];
    logic [NUM_CH-1:0]  npos_lane;
    logic [MUL_BW-1:0]  lut_rd    [NUM_CH];

    // Stage 2 combinational lane results
    logic [P_BW-1:0]          shamt      [NUM_CH];
    logic signed [MUL_BW-1:0] div_res    [NUM_CH];
    logic [MUL_BW-1:0]        lane_scale [NUM_CH];
    logic [NUM_CH-1:0]        lane_dz;

    // A stage may move when its successor is free or being emptied this cycle.
    always_comb begin
        s2_adv   = ~out_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = s1_adv;
        accept   = in_valid & s1_adv;
    end

    // Per-lane decode: leading-one position, nonpositive test, table read of the current contents.
    always_comb begin
        npos_lane = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            x_lane[k]   = x_i[k*MUL_BW +: MUL_BW];
            idx_lane[k] = x_lane[k][FRA_BW+INT_BW-1:FRA_BW];
            lut_rd[k]   = lut_q[idx_lane[k]];
            p_lane[k]   = '0;
            for (int i = 0; i < MUL_BW; i++) begin
                if (x_lane[k][i]) begin
                    p_lane[k] = P_BW'(i);
                end
            end
            npos_lane[k] = x_lane[k][MUL_BW-1] | (x_lane[k] == '0);
        end
    end

    // Stage 1 next state: capture a transaction on accept, otherwise hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_npos_d  = s1_npos_q;
        for (int k = 0; k < NUM_CH; k++) begin
            s1_y_d[k]   = s1_y_q[k];
            s1_p_d[k]   = s1_p_q[k];
            s1_lut_d[k] = s1_lut_q[k];
        end
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_mode_d = mode_e'(mode_i);
            s1_npos_d = npos_lane;
            for (int k = 0; k < NUM_CH; k++) begin
                s1_y_d[k]   = y_i[k*MUL_BW +: MUL_BW];
                s1_p_d[k]   = p_lane[k];
                s1_lut_d[k] = lut_rd[k];
            end
        end
    end

    // Stage 1 register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_GEMM;
            s1_npos_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                s1_y_q[k]   <= '0;
                s1_p_q[k]   <= '0;
                s1_lut_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_npos_q  <= s1_npos_d;
            for (int k = 0; k < NUM_CH; k++) begin
                s1_y_q[k]   <= s1_y_d[k];
                s1_p_q[k]   <= s1_p_d[k];
                s1_lut_q[k] <= s1_lut_d[k];
            end
        end
    end

    // Per-lane result select: div shifts y by one past the leading-one position.
    always_comb begin
        lane_dz = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            shamt[k]      = s1_p_q[k] + P_BW'(1);
            div_res[k]    = $signed(s1_y_q[k]) >>> shamt[k];
            lane_scale[k] = '0;
            unique case (s1_mode_q)
                MODE_GEMM: lane_scale[k] = '0;
                MODE_DIV: begin
                    if (s1_npos_q[k]) begin
                        lane_scale[k] = MAX_POS;
                        lane_dz[k]    = 1'b1;
                    end else begin
                        lane_scale[k] = div_res[k];
                    end
                end
                MODE_EXP:  lane_scale[k] = s1_lut_q[k];
                MODE_LOG:  lane_scale[k] = '1;
            endcase
        end
    end

    // Stage 2 next state: load from stage 1 when advancing, otherwise hold the output.
    always_comb begin
        out_valid_d = out_valid_q;
        dz_d        = dz_q;
        for (int k = 0; k < NUM_CH; k++) begin
            scale_d[k] = scale_q[k];
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dz_d = lane_dz;
                for (int k = 0; k < NUM_CH; k++) begin
                    scale_d[k] = lane_scale[k];
                end
            end
        end
    end

    // Stage 2 register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dz_q        <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                scale_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            dz_q        <= dz_d;
            for (int k = 0; k < NUM_CH; k++) begin
                scale_q[k] <= scale_d[k];
            end
        end
    end

    // Table write port; a same-edge read in stage 1 still sees the old entry.
    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d[lut_addr] = lut_wdata;
        end
    end

    // Exp table storage, reset to 1.0 in every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= LUT_ONE;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    // Flatten the lane registers onto the output buses.
    always_comb begin
        scale_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scale_o[k*MUL_BW +: MUL_BW] = scale_q[k];
        end
        dz_o      = dz_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_scale_gen_pipe.sv
// tb_scale_gen_pipe
// Directed vectors, hand-written multi-cycle sequences and randomized traffic
// for scale_gen_pipe, all checked against a transaction-level reference model.

module tb_scale_gen_pipe;

    localparam logic [1:0] M_GEMM = 2'b00;
    localparam logic [1:0] M_DIV  = 2'b01;
    localparam logic [1:0] M_EXP  = 2'b10;
    localparam logic [1:0] M_LOG  = 2'b11;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode_i;
    logic [63:0] x_i;
    logic [63:0] y_i;
    logic        lut_we;
    logic [5:0]  lut_addr;
    logic [15:0] lut_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] scale_o;
    logic [3:0]  dz_o;

    scale_gen_pipe #(
        .NUM_CH(4),
        .MUL_BW(16),
        .FRA_BW(10),
        .INT_BW(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode_i(mode_i),
        .x_i(x_i),
        .y_i(y_i),
        .lut_we(lut_we),
        .lut_addr(lut_addr),
        .lut_wdata(lut_wdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .scale_o(scale_o),
        .dz_o(dz_o)
    );

    // Free-running clock and edge counter used to age transactions in the model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] scale;
        logic [3:0]  dz;
        int          acc;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] scale;
        logic [3:0]  dz;
    } vec_t;

    exp_t        model_q[$];
    logic [15:0] lut_m[64];
    vec_t        vecs[7];
    int          checks = 0;
    int          errors = 0;
    logic        last_accepted = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        model_q.delete();
        for (int i = 0; i < 64; i++) lut_m[i] = 16'h0400;
    endtask

    // Reference: one lane, straight from the arithmetic definition of each mode.
    function automatic logic [15:0] refLane(input logic [1:0] md, input logic [15:0] xv,
                                            input logic [15:0] yv, output logic dz);
        int xs;
        int ys;
        int p;
        int den;
        int q;
        logic [15:0] r;
        dz = 1'b0;
        xs = int'($signed(xv));
        ys = int'($signed(yv));
        r  = 16'h0000;
        case (md)
            M_GEMM: r = 16'h0000;
            M_DIV: begin
                if (xs <= 0) begin
                    dz = 1'b1;
                    r  = 16'h7FFF;
                end else begin
                    p = 0;
                    while ((1 << (p + 1)) <= xs) p++;
                    den = 1 << (p + 1);
                    q = ys / den;
                    if ((ys % den != 0) && (ys < 0)) q = q - 1;
                    r = 16'(q);
                end
            end
            M_EXP: r = lut_m[xv[15:10]];
            default: r = 16'hFFFF;
        endcase
        return r;
    endfunction

    function automatic exp_t refTxn(input logic [1:0] md, input logic [63:0] xv, input logic [63:0] yv, input int acc);
        exp_t e;
        logic d;
        e.acc = acc;
        e.dz  = '0;
        e.scale = '0;
        for (int l = 0; l < 4; l++) begin
            e.scale[l*16 +: 16] = refLane(md, xv[l*16 +: 16], yv[l*16 +: 16], d);
            e.dz[l] = d;
        end
        return e;
    endfunction

    // One cycle: drive at the falling edge, check against the model, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [1:0] md, input logic [63:0] xv,
                                 input logic [63:0] yv, input logic ordy, input logic we,
                                 input logic [5:0] wa, input logic [15:0] wd);
        logic exp_ready;
        logic exp_ov;
        exp_t dropped;
        @(negedge clk);
        in_valid  = iv;
        mode_i    = md;
        x_i       = xv;
        y_i       = yv;
        out_ready = ordy;
        lut_we    = we;
        lut_addr  = wa;
        lut_wdata = wd;
        #1;
        exp_ready = (model_q.size() < 2) || ordy;
        exp_ov    = (model_q.size() > 0) && ((cyc - model_q[0].acc) >= 2);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            checkOutput("scale", scale_o, model_q[0].scale);
            checkOutput("dz", 64'(dz_o), 64'(model_q[0].dz));
            if (ordy) dropped = model_q.pop_front();
        end
        last_accepted = iv && exp_ready;
        if (last_accepted) model_q.push_back(refTxn(md, xv, yv, cyc));
        if (we) lut_m[wa] = wd;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, M_GEMM, 64'h0, 64'h0, ordy, 1'b0, 6'd0, 16'h0);
    endtask

    initial begin
        logic [63:0] xv;
        logic [63:0] yv;
        logic [1:0]  md;
        logic        we;
        logic [5:0]  wa;
        int          k;

        vecs[0] = '{M_GEMM, 64'h1234_8000_0001_7FFF, 64'hAAAA_5555_0F0F_F0F0, 64'h0, 4'b0000};
        vecs[1] = '{M_LOG,  64'h0400_0400_0400_0400, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000};
        vecs[2] = '{M_DIV,  64'h0400_0400_0400_0400, 64'h7FFF_0001_C000_4000, 64'h000F_0000_FFF8_0008, 4'b0000};
        vecs[3] = '{M_DIV,  64'hFFFF_0001_8000_0000, 64'h1234_1234_1234_1234, 64'h7FFF_091A_7FFF_7FFF, 4'b1011};
        vecs[4] = '{M_EXP,  64'h0C00_0C00_0C00_0C00, 64'h0,                   64'h0400_0400_0400_0400, 4'b0000};
        vecs[5] = '{M_DIV,  64'h0010_7FFF_0003_4000, 64'h0100_7FFF_FFFF_8000, 64'h0008_0000_FFFF_FFFF, 4'b0000};
        vecs[6] = '{M_EXP,  64'h0C00_03FF_FC00_0000, 64'h0,                   64'h0400_0400_0400_0400, 4'b0000};

        rst = 1'b0;
        in_valid = 1'b0; mode_i = '0; x_i = '0; y_i = '0;
        out_ready = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        resetModel();
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_scale", scale_o, 64'h0);
        checkOutput("reset_dz", 64'(dz_o), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] gemm then log back-to-back");
        applyStimulus(1'b1, M_GEMM, 64'h0123_4567_89AB_CDEF, 64'h1, 1'b1, 1'b0, 6'd0, 16'h0);
        applyStimulus(1'b1, M_LOG,  64'h0123_4567_89AB_CDEF, 64'h1, 1'b1, 1'b0, 6'd0, 16'h0);
        idle(1'b1);
        checkOutput("b2b_gemm_valid", 64'(out_valid), 64'h1);
        checkOutput("b2b_gemm_scale", scale_o, 64'h0);
        idle(1'b1);
        checkOutput("b2b_log_valid", 64'(out_valid), 64'h1);
        checkOutput("b2b_log_scale", scale_o, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("b2b_log_dz", 64'(dz_o), 64'h0);
        idle(1'b1);
        checkOutput("b2b_empty", 64'(out_valid), 64'h0);

        $display("[TB] directed vector table");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(1'b1, vecs[v].mode, vecs[v].x, vecs[v].y, 1'b1, 1'b0, 6'd0, 16'h0);
            idle(1'b1);
            checkOutput($sformatf("vec%0d_not_early", v), 64'(out_valid), 64'h0);
            idle(1'b1);
            checkOutput($sformatf("vec%0d_valid", v), 64'(out_valid), 64'h1);
            checkOutput($sformatf("vec%0d_scale", v), scale_o, vecs[v].scale);
            checkOutput($sformatf("vec%0d_dz", v), 64'(dz_o), 64'(vecs[v].dz));
        end

        $display("[TB] exp table write and same-cycle hazard");
        applyStimulus(1'b0, M_GEMM, 64'h0, 64'h0, 1'b1, 1'b1, 6'd3, 16'h5060);
        applyStimulus(1'b1, M_EXP, {4{16'h0C00}}, 64'h0, 1'b1, 1'b0, 6'd0, 16'h0);
        applyStimulus(1'b1, M_EXP, {4{16'h0C00}}, 64'h0, 1'b1, 1'b1, 6'd3, 16'h1111);
        applyStimulus(1'b1, M_EXP, {4{16'h0C00}}, 64'h0, 1'b1, 1'b0, 6'd0, 16'h0);
        checkOutput("haz_written", scale_o, {4{16'h5060}});
        idle(1'b1);
        checkOutput("haz_same_cycle", scale_o, {4{16'h5060}});
        idle(1'b1);
        checkOutput("haz_next", scale_o, {4{16'h1111}});
        idle(1'b1);

        $display("[TB] backpressure with five queued transactions");
        k = 0;
        for (int c = 0; c < 30; c++) begin
            if (k < 5) begin
                for (int l = 0; l < 4; l++) yv[l*16 +: 16] = 16'h1000 + 16'(k * 256 + l * 16);
                applyStimulus(1'b1, M_DIV, {4{16'h0001}}, yv, (c >= 4), 1'b0, 6'd0, 16'h0);
            end else begin
                idle(c >= 4);
            end
            if (last_accepted) k++;
            if (c == 3) checkOutput("bp_accepted_in_stall", 64'(k), 64'd2);
        end
        checkOutput("bp_all_accepted", 64'(k), 64'd5);
        checkOutput("bp_drained", 64'(model_q.size()), 64'd0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b0, M_GEMM, 64'h0, 64'h0, 1'b1, 1'b1, 6'd5, 16'h7777);
        applyStimulus(1'b1, M_EXP, {4{16'h1400}}, 64'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        applyStimulus(1'b1, M_EXP, {4{16'h0C00}}, 64'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        idle(1'b0);
        checkOutput("rst_pre_valid", 64'(out_valid), 64'h1);
        checkOutput("rst_pre_scale", scale_o, {4{16'h7777}});
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_mid_scale", scale_o, 64'h0);
        resetModel();
        @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) idle(1'b1);
        applyStimulus(1'b1, M_EXP, 64'h0C00_1400_0C00_1400, 64'h0, 1'b1, 1'b0, 6'd0, 16'h0);
        idle(1'b1);
        idle(1'b1);
        checkOutput("rst_table_default", scale_o, {4{16'h0400}});
        idle(1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            md = 2'($urandom_range(0, 3));
            xv = {$urandom(), $urandom()};
            yv = {$urandom(), $urandom()};
            we = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 1) == 0) ? xv[15:10] : 6'($urandom_range(0, 63));
            applyStimulus(($urandom_range(0, 9) < 7), md, xv, yv, ($urandom_range(0, 9) < 7),
                          we, wa, 16'($urandom()));
        end
        for (int c = 0; c < 4; c++) idle(1'b1);
        checkOutput("rand_drained", 64'(model_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
